// File: rtl/cpu_rf.sv
// cpu_rf: 16x32 register file, two registered read ports, one write port, read-of-unwritten flag.
// Define CPU_RF_BYPASS_EN for write-first forwarding; the default build is read-first.
module cpu_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sel1,
  input  logic [3:0]  sel2,
  input  logic [3:0]  wrt_sel,
  input  logic [31:0] wrt_data,
  input  logic        wrt_en,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic        err
);
  logic [31:0] mem [16];
  logic [15:0] valid;
  logic        hit1, hit2;
  logic [31:0] rd1, rd2;
  logic        v1, v2;
`ifdef CPU_RF_BYPASS_EN
  // a same-edge write to the selected index is forwarded and counts as written
  assign hit1 = wrt_en && (wrt_sel == sel1);
  assign hit2 = wrt_en && (wrt_sel == sel2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  always_comb begin
    rd1 = hit1 ? wrt_data : mem[sel1];
    rd2 = hit2 ? wrt_data : mem[sel2];
    v1  = valid[sel1] | hit1;
    v2  = valid[sel2] | hit2;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      valid <= '0;
      reg1  <= '0;
      reg2  <= '0;
      err   <= 1'b0;
    end else begin
      if (wrt_en) begin
        mem[wrt_sel]   <= wrt_data;
        valid[wrt_sel] <= 1'b1;
      end
      reg1 <= rd1;
      reg2 <= rd2;
      err  <= !(v1 && v2);
    end
  end
endmodule

// File: tb/tb_cpu_rf.sv
// tb_cpu_rf: directed and random checks of cpu_rf against a shadow register model.
module tb_cpu_rf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel1 = '0, sel2 = '0, wrt_sel = '0;
  logic [31:0] wrt_data = '0;
  logic        wrt_en = 1'b0;
  logic [31:0] reg1, reg2;
  logic        err;
  int checks = 0;
  int errors = 0;
`ifdef CPU_RF_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        e;
  } exp_t;
  logic [31:0] mdl [16];
  logic [15:0] mv;
  exp_t sb [$];
  always #5 clk = ~clk;
  cpu_rf dut (
    .clk(clk), .rst_n(rst_n), .sel1(sel1), .sel2(sel2), .wrt_sel(wrt_sel),
    .wrt_data(wrt_data), .wrt_en(wrt_en), .reg1(reg1), .reg2(reg2), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // drives one cycle from a negedge, predicts the outputs, and checks them at the next negedge
  task automatic cyc(input string tag, input logic rn, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] ws, input logic [31:0] wd, input logic we);
    exp_t x, g;
    logic h1, h2;
    rst_n = rn; sel1 = s1; sel2 = s2; wrt_sel = ws; wrt_data = wd; wrt_en = we;
    h1 = BP && we && (ws == s1);
    h2 = BP && we && (ws == s2);
    if (!rn) x = '0;
    else begin
      x.r1 = h1 ? wd : mdl[s1];
      x.r2 = h2 ? wd : mdl[s2];
      x.e  = !((mv[s1] || h1) && (mv[s2] || h2));
    end
    sb.push_back(x);
    if (!rn) begin
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      mv = '0;
    end else if (we) begin
      mdl[ws] = wd;
      mv[ws]  = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    g = sb.pop_front();
    chk({tag, ".reg1"}, reg1, g.r1);
    chk({tag, ".reg2"}, reg2, g.r2);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, g.e});
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    mv = '0;
    @(negedge clk);
    cyc("reset", 1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0);
    cyc("reset_wr", 1'b0, 4'h1, 4'h2, 4'h1, 32'hAAAA5555, 1'b1);
    chk("reset_err_const", {31'b0, err}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc("unwritten", 1'b1, 4'(i), 4'h0, 4'h0, 32'h0, 1'b0);
      chk("unwritten_const", reg1, 32'h0);
    end
    chk("unwritten_err_const", {31'b0, err}, 32'h1);
    cyc("wr5", 1'b1, 4'h0, 4'h0, 4'h5, 32'hDEADBEEF, 1'b1);
    cyc("rd5", 1'b1, 4'h5, 4'h5, 4'h0, 32'h0, 1'b0);
    chk("rd5_const1", reg1, 32'hDEADBEEF);
    chk("rd5_const2", reg2, 32'hDEADBEEF);
    chk("rd5_err_const", {31'b0, err}, 32'h0);
    cyc("nowr3", 1'b1, 4'h0, 4'h0, 4'h3, 32'h12345678, 1'b0);
    cyc("rd3", 1'b1, 4'h3, 4'h5, 4'h0, 32'h0, 1'b0);
    chk("rd3_const", reg1, 32'h0);
    chk("rd3_err_const", {31'b0, err}, 32'h1);
    cyc("wrA1", 1'b1, 4'h5, 4'h5, 4'hA, 32'h1, 1'b1);
    cyc("wrA_same", 1'b1, 4'hA, 4'h5, 4'hA, 32'hCAFEF00D, 1'b1);
    chk("bypass_const", reg1, BP ? 32'hCAFEF00D : 32'h1);
    cyc("rdA", 1'b1, 4'hA, 4'hA, 4'h0, 32'h0, 1'b0);
    chk("rdA_const", reg2, 32'hCAFEF00D);
    cyc("wrF", 1'b1, 4'h5, 4'hA, 4'hF, 32'hFFFFFFFF, 1'b1);
    cyc("rdF", 1'b1, 4'hF, 4'h5, 4'h0, 32'h0, 1'b0);
    cyc("rst_wrF", 1'b0, 4'hF, 4'hF, 4'hF, 32'h55, 1'b1);
    cyc("rdF_after", 1'b1, 4'hF, 4'hF, 4'h0, 32'h0, 1'b0);
    chk("rdF_const", reg1, 32'h0);
    chk("rdF_err_const", {31'b0, err}, 32'h1);
    for (int i = 0; i < 100; i++)
      cyc("rnd", 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 32'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 16; i++)
      cyc("sweep", 1'b1, 4'(i), 4'(15 - i), 4'h0, 32'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
